// File: rtl/reverse_arbiter_pkg.sv
// reverse_arbiter_pkg: shared FSM encoding and sizing constants for the reverse arbiter
package reverse_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;
    localparam int N_REQ_MAX = 8;
    localparam int DATA_W = 32;
endpackage

// File: rtl/reverse_arbiter_if.sv
// reverse_arbiter_if: request-side and result-side handshake bundle
interface reverse_arbiter_if #(parameter int N_REQ = 4);
    import reverse_arbiter_pkg::*;
    localparam int IDW = $clog2(N_REQ);
    logic [N_REQ-1:0]        req_valid;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_rev;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [IDW-1:0]          out_id;
    logic                    out_ready;
    modport master (
        output req_valid, req_data, req_rev, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
    modport slave (
        input  req_valid, req_data, req_rev, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/reverse_32bit.sv
// reverse_32bit: optional bit-order reversal of a 32-bit word
module reverse_32bit (
    input  logic [31:0] in,
    input  logic        rev,
    output logic [31:0] out
);
    logic [31:0] r;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign r[i] = in[31-i];
    end
    assign out = rev ? r : in;
endmodule

// File: rtl/reverse_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);
    logic           found;
    logic [IDW-1:0] k;
    // scan from ptr upward with wrap; the first hit is kept
    always_comb begin
        found = 1'b0;
        idx = '0;
        k = '0;
        for (int i = 0; i < N; i++) begin
            k = IDW'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found = 1'b1;
                idx = k;
            end
        end
        gnt = found ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/reverse_arbiter.sv
// reverse_arbiter: round-robin sharing of one bit-reverse unit with a registered valid/ready result
module reverse_arbiter
    import reverse_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input logic clk,
    input logic rst_n,
    reverse_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    state_t            state, next_state;
    logic [IDW-1:0]    ptr, id_q, g_idx;
    logic [N_REQ-1:0]  g_hot;
    logic [DATA_W-1:0] opnd, rev_out;
    logic              rev_q, grant;
    logic [DATA_W-1:0] words [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_word
        assign words[k] = bus.req_data[DATA_W*k +: DATA_W];
    end
    rr_pick #(.N(N_REQ)) u_pick (
        .req(bus.req_valid),
        .ptr(ptr),
        .gnt(g_hot),
        .idx(g_idx)
    );
    reverse_32bit u_rev (
        .in(opnd),
        .rev(rev_q),
        .out(rev_out)
    );
    // grants only leave the block while idle and out of reset
    assign bus.req_ready = (state == IDLE && rst_n) ? g_hot : '0;
    assign grant = |bus.req_ready;
    // next-state: accept in IDLE, one compute cycle, hold until consumed
    always_comb begin
        next_state = state;
        if (state == IDLE && grant) next_state = EXEC;
        if (state == EXEC) next_state = HOLD;
        if (state == HOLD && bus.out_ready) next_state = IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end
    // operand capture on grant, result capture in EXEC, release on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            opnd <= '0;
            rev_q <= 1'b0;
            id_q <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_id <= '0;
        end else begin
            if (grant) begin
                opnd <= words[g_idx];
                rev_q <= bus.req_rev[g_idx];
                id_q <= g_idx;
                ptr <= (g_idx == IDW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
            end
            if (state == EXEC) begin
                bus.out_data <= rev_out;
                bus.out_id <= id_q;
                bus.out_valid <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reverse_arbiter.sv
// tb_reverse_arbiter: scoreboard bench with a transaction-level arbitration model
module tb_reverse_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    reverse_arbiter_if #(.N_REQ(N)) bus ();
    reverse_arbiter #(.N_REQ(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    int total = 0;
    int passed = 0;
    logic [31:0] exp_d[$];
    int exp_id[$];
    int mptr = 0;
    int busy = 0;
    int mg;
    logic [31:0] md, mr;
    int n_acc = 0;
    logic [31:0] last_data;
    int last_id;
    int base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model: who wins, what the result must be, and when the unit is busy
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(bus.out_valid), 0);
            chk("rst_out_data", 64'(bus.out_data), 0);
            chk("rst_out_id", 64'(bus.out_id), 0);
            chk("rst_req_ready", 64'(bus.req_ready), 0);
            mptr = 0;
            busy = 0;
            exp_d.delete();
            exp_id.delete();
        end else begin
            mg = -1;
            if (busy == 0)
                for (int i = 0; i < N; i++)
                    if (mg < 0 && bus.req_valid[(mptr + i) % N]) mg = (mptr + i) % N;
            chk("req_ready", 64'(bus.req_ready), mg < 0 ? 64'd0 : (64'd1 << mg));
            chk("out_valid", 64'(bus.out_valid), 64'(busy == 2));
            if (mg >= 0) begin
                md = bus.req_data[32*mg +: 32];
                mr = {<<{md}};
                exp_d.push_back(bus.req_rev[mg] ? mr : md);
                exp_id.push_back(mg);
                mptr = (mg + 1) % N;
                busy = 1;
            end else if (busy == 1) begin
                busy = 2;
            end else if (busy == 2 && bus.out_ready) begin
                busy = 0;
            end
        end
    end

    // monitor: every presented result must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_d.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_valid), 0);
            end else begin
                chk("out_data", 64'(bus.out_data), 64'(exp_d[0]));
                chk("out_id", 64'(bus.out_id), 64'(exp_id[0]));
                if (bus.out_ready) begin
                    last_data = bus.out_data;
                    last_id = int'(bus.out_id);
                    n_acc++;
                    void'(exp_d.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (n_acc < target && t < 40) begin
            tick();
            t++;
        end
        chk("accept_timeout", 64'(n_acc >= target), 1);
    endtask

    task automatic one_req(input int k, input logic [31:0] d, input logic r);
        bus.req_data[32*k +: 32] = d;
        bus.req_rev[k] = r;
        bus.req_valid = 4'b0001 << k;
        tick();
        bus.req_valid = '0;
    endtask

    initial begin
        int t;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_rev = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        one_req(0, 32'h00000001, 1'b1);
        wait_acc(1);
        chk("single_data", 64'(last_data), 64'h80000000);
        chk("single_id", 64'(last_id), 0);
        one_req(2, 32'h12345678, 1'b0);
        wait_acc(2);
        chk("pass_data", 64'(last_data), 64'h12345678);
        chk("pass_id", 64'(last_id), 2);
        one_req(2, 32'hA5A5_0F0F, 1'b1);
        wait_acc(3);
        chk("skip_id", 64'(last_id), 2);
        one_req(3, 32'hC0DE_0001, 1'b1);
        wait_acc(4);
        chk("ptr_kept_id", 64'(last_id), 3);
        for (int k = 0; k < N; k++) bus.req_data[32*k +: 32] = 32'h0000FFFF;
        bus.req_rev = '1;
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_acc(5 + k);
            chk("rr_id", 64'(last_id), 64'(k % N));
            chk("rr_data", 64'(last_data), 64'hFFFF0000);
        end
        bus.req_data = {32'h0BAD_F00D, 32'h1111_2222, 32'h8000_0001, 32'h0F0F_0F0F};
        bus.out_ready = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("bp_reach_hold", 64'(bus.out_valid), 1);
        repeat (5) tick();
        bus.out_ready = 1'b1;
        base = n_acc;
        wait_acc(base + 2);
        t = 0;
        while (bus.req_ready == '0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 0);
        chk("async_rst_data", 64'(bus.out_data), 0);
        chk("async_rst_id", 64'(bus.out_id), 0);
        bus.req_valid = 4'b1010;
        tick();
        rst_n = 1'b1;
        base = n_acc;
        wait_acc(base + 1);
        chk("post_rst_id", 64'(last_id), 1);
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) bus.req_data[32*k +: 32] = $urandom();
            bus.req_rev = 4'($urandom_range(0, 15));
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        chk("sb_drained", 64'(exp_d.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
